// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the ALU decoder and the register-file/writeback stage.
// Opcode/funct encodings, datapath width, register address type and writeback kinds.
package mips_isa_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_GPR,
    WB_HILO
  } wb_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // R-type functs whose result lands in GPR rd (the trapping add/sub are handled separately).
  function automatic logic funct_writes_gpr(input logic [5:0] funct);
    case (funct)
      F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 GPR storage: two async read ports, one sync write port, $0 hardwired to zero,
// plus an independent debug read of committed contents.
module regfile_2r1w
  import mips_isa_pkg::*;
#(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   i_raddr1,
  output logic [W-1:0] o_rdata1,
  input  logic [4:0]   i_raddr2,
  output logic [W-1:0] o_rdata2,
  input  logic         i_we,
  input  logic [4:0]   i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [4:0]   i_dbg_addr,
  output logic [W-1:0] o_dbg_rdata
);

  logic [W-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1    = (i_raddr1 == 5'd0)   ? '0 : r_mem[i_raddr1];
  assign o_rdata2    = (i_raddr2 == 5'd0)   ? '0 : r_mem[i_raddr2];
  assign o_dbg_rdata = (i_dbg_addr == 5'd0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_regfile_wb.sv
// Register-file and writeback end of the ALU datapath: operand fetch with forwarding,
// instruction decode, one-entry writeback register, HI/LO and status pulses.
module alu_regfile_wb #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] gr1,
  output logic [XLEN-1:0] gr2,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] alu_hi,
  input  logic [XLEN-1:0] alu_lo,
  input  logic            alu_overflow,
  output logic            wb_done,
  output logic            exc_ovf,
  output logic            illegal,
  output logic [XLEN-1:0] hi_q,
  output logic [XLEN-1:0] lo_q,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_rdata
);

  import mips_isa_pkg::*;

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  reg_addr_t       w_rs;
  reg_addr_t       w_rt;
  reg_addr_t       w_rd;
  wb_kind_e        w_kind;
  reg_addr_t       w_dest;
  logic            w_trap;
  logic            w_illegal;
  logic            w_commit;
  logic [XLEN-1:0] w_rf_rd1;
  logic [XLEN-1:0] w_rf_rd2;
  logic            w_rf_we;

  logic            r_wb_valid;
  wb_kind_e        r_wb_kind;
  reg_addr_t       r_wb_addr;
  logic [XLEN-1:0] r_wb_data;
  logic [XLEN-1:0] r_wb_hi;
  logic [XLEN-1:0] r_wb_lo;
  logic            r_exc_ovf;
  logic            r_illegal;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_rs    = instr[25:21];
  assign w_rt    = instr[20:16];
  assign w_rd    = instr[15:11];

  // Classify the instruction into GPR / HI-LO / no write, trap or illegal.
  always_comb begin
    w_kind    = WB_NONE;
    w_dest    = '0;
    w_trap    = 1'b0;
    w_illegal = 1'b0;
    if (instr_valid) begin
      case (w_op)
        OP_RTYPE: begin
          if (w_funct == F_ADD || w_funct == F_SUB) begin
            if (alu_overflow) begin
              w_trap = 1'b1;
            end else begin
              w_kind = WB_GPR;
              w_dest = w_rd;
            end
          end else if (funct_writes_gpr(w_funct)) begin
            w_kind = WB_GPR;
            w_dest = w_rd;
          end else if (w_funct == F_MULT || w_funct == F_MULTU ||
                       w_funct == F_DIV  || w_funct == F_DIVU) begin
            w_kind = WB_HILO;
          end else begin
            w_illegal = 1'b1;
          end
        end
        OP_ADDI: begin
          if (alu_overflow) begin
            w_trap = 1'b1;
          end else begin
            w_kind = WB_GPR;
            w_dest = w_rt;
          end
        end
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
          w_kind = WB_GPR;
          w_dest = w_rt;
        end
        OP_BEQ, OP_BNE, OP_LW, OP_SW: begin
          w_kind = WB_NONE;
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // Writes to $0 are dropped here so they never raise wb_done.
  assign w_commit = (w_kind == WB_HILO) || ((w_kind == WB_GPR) && (w_dest != 5'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_kind  <= WB_NONE;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_hi    <= '0;
      r_wb_lo    <= '0;
      r_exc_ovf  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_valid <= w_commit;
      r_wb_kind  <= w_kind;
      r_wb_addr  <= w_dest;
      r_wb_data  <= alu_out;
      r_wb_hi    <= alu_hi;
      r_wb_lo    <= alu_lo;
      r_exc_ovf  <= w_trap;
      r_illegal  <= w_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_wb_valid && (r_wb_kind == WB_HILO)) begin
      r_hi <= r_wb_hi;
      r_lo <= r_wb_lo;
    end
  end

  assign w_rf_we = r_wb_valid && (r_wb_kind == WB_GPR);

  regfile_2r1w #(
    .NREG (NREG),
    .W    (XLEN)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_raddr1    (w_rs),
    .o_rdata1    (w_rf_rd1),
    .i_raddr2    (w_rt),
    .o_rdata2    (w_rf_rd2),
    .i_we        (w_rf_we),
    .i_waddr     (r_wb_addr),
    .i_wdata     (r_wb_data),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_rdata (dbg_rdata)
  );

  // The pending W-stage write bypasses the array so back-to-back RAW reads see it.
  assign gr1 = (w_rs == 5'd0) ? '0 :
               (w_rf_we && (r_wb_addr == w_rs)) ? r_wb_data : w_rf_rd1;
  assign gr2 = (w_rt == 5'd0) ? '0 :
               (w_rf_we && (r_wb_addr == w_rt)) ? r_wb_data : w_rf_rd2;

  assign wb_done = r_wb_valid;
  assign exc_ovf = r_exc_ovf;
  assign illegal = r_illegal;
  assign hi_q    = r_hi;
  assign lo_q    = r_lo;

endmodule

// File: tb/tb_alu_regfile_wb.sv
// Directed, table-driven bench for alu_regfile_wb with hand-computed expectations
// and hand-written sequences for forwarding and mid-operation reset.
module tb_alu_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic [31:0] alu_out;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        alu_overflow;
  logic        wb_done;
  logic        exc_ovf;
  logic        illegal;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] aluOut;
    logic [31:0] aluHi;
    logic [31:0] aluLo;
    logic        ovf;
    logic [31:0] expGr1;
    logic [31:0] expGr2;
    logic        expDone;
    logic        expExc;
    logic        expIll;
    logic [4:0]  dbgAddr;
    logic [31:0] expDbg;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  alu_regfile_wb #(
    .NREG (32),
    .XLEN (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .gr1          (gr1),
    .gr2          (gr2),
    .alu_out      (alu_out),
    .alu_hi       (alu_hi),
    .alu_lo       (alu_lo),
    .alu_overflow (alu_overflow),
    .wb_done      (wb_done),
    .exc_ovf      (exc_ovf),
    .illegal      (illegal),
    .hi_q         (hi_q),
    .lo_q         (lo_q),
    .dbg_addr     (dbg_addr),
    .dbg_rdata    (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkPulses(input string tag, input logic d, input logic e, input logic i);
    checkOutput({tag, " wb_done"}, {31'b0, wb_done}, {31'b0, d});
    checkOutput({tag, " exc_ovf"}, {31'b0, exc_ovf}, {31'b0, e});
    checkOutput({tag, " illegal"}, {31'b0, illegal}, {31'b0, i});
  endtask

  // Issue one instruction, then idle a cycle so it commits before the next one.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    instr_valid  = 1'b1;
    instr        = v.instr;
    alu_out      = v.aluOut;
    alu_hi       = v.aluHi;
    alu_lo       = v.aluLo;
    alu_overflow = v.ovf;
    #1;
    checkOutput({tag, " gr1"}, gr1, v.expGr1);
    checkOutput({tag, " gr2"}, gr2, v.expGr2);
    @(posedge clk); #1;
    instr_valid  = 1'b0;
    alu_overflow = 1'b0;
    checkPulses(tag, v.expDone, v.expExc, v.expIll);
    @(posedge clk); #1;
    dbg_addr = v.dbgAddr;
    #1;
    checkOutput({tag, " dbg_rdata"}, dbg_rdata, v.expDbg);
    checkOutput({tag, " hi_q"}, hi_q, v.expHi);
    checkOutput({tag, " lo_q"}, lo_q, v.expLo);
  endtask

  initial begin
    //          instr         aluOut        aluHi         aluLo         ovf   gr1           gr2           done  exc   ill   dbg    expDbg        hi            lo
    vecs[0]  = '{32'h24110064, 32'h00000064, 32'h0,       32'h0,       1'b0, 32'h0,        32'h00000064, 1'b1, 1'b0, 1'b0, 5'd17, 32'h00000064, 32'h0,       32'h0};
    vecs[1]  = '{32'h34090005, 32'h11111111, 32'h0,       32'h0,       1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd9,  32'h11111111, 32'h0,       32'h0};
    vecs[2]  = '{32'h20080001, 32'h0000DEAD, 32'h0,       32'h0,       1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 5'd8,  32'h0,        32'h0,       32'h0};
    vecs[3]  = '{32'h012A4020, 32'hABBBBBBA, 32'h0,       32'h0,       1'b1, 32'h11111111, 32'h0,        1'b0, 1'b1, 1'b0, 5'd8,  32'h0,        32'h0,       32'h0};
    vecs[4]  = '{32'h012A4020, 32'h00000005, 32'h0,       32'h0,       1'b0, 32'h11111111, 32'h0,        1'b1, 1'b0, 1'b0, 5'd8,  32'h00000005, 32'h0,       32'h0};
    vecs[5]  = '{32'h00095080, 32'h44444444, 32'h0,       32'h0,       1'b0, 32'h0,        32'h11111111, 1'b1, 1'b0, 1'b0, 5'd10, 32'h44444444, 32'h0,       32'h0};
    vecs[6]  = '{32'h014B0018, 32'h0000FFFF, 32'h1234,    32'h5678,    1'b0, 32'h44444444, 32'h0,        1'b1, 1'b0, 1'b0, 5'd10, 32'h44444444, 32'h1234,    32'h5678};
    vecs[7]  = '{32'h24000005, 32'h00000005, 32'h0,       32'h0,       1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1234,    32'h5678};
    vecs[8]  = '{32'hFC000000, 32'h00000077, 32'h0,       32'h0,       1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd17, 32'h00000064, 32'h1234,    32'h5678};
    vecs[9]  = '{32'h10000000, 32'h00000077, 32'h0,       32'h0,       1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd17, 32'h00000064, 32'h1234,    32'h5678};
    vecs[10] = '{32'hAC110000, 32'h00000077, 32'h0,       32'h0,       1'b0, 32'h0,        32'h00000064, 1'b0, 1'b0, 1'b0, 5'd17, 32'h00000064, 32'h1234,    32'h5678};
    vecs[11] = '{32'h00000001, 32'h00000077, 32'h0,       32'h0,       1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        32'h1234,    32'h5678};
    vecs[12] = '{32'h012A4022, 32'h00000099, 32'h0,       32'h0,       1'b1, 32'h11111111, 32'h44444444, 1'b0, 1'b1, 1'b0, 5'd8,  32'h00000005, 32'h1234,    32'h5678};
    vecs[13] = '{32'h012A4023, 32'h00000077, 32'h0,       32'h0,       1'b1, 32'h11111111, 32'h44444444, 1'b1, 1'b0, 1'b0, 5'd8,  32'h00000077, 32'h1234,    32'h5678};
    vecs[14] = '{32'h012A582A, 32'h00000001, 32'h0,       32'h0,       1'b0, 32'h11111111, 32'h44444444, 1'b1, 1'b0, 1'b0, 5'd11, 32'h00000001, 32'h1234,    32'h5678};
    vecs[15] = '{32'h012A0021, 32'h00000055, 32'h0,       32'h0,       1'b0, 32'h11111111, 32'h44444444, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h1234,    32'h5678};
    vecs[16] = '{32'h012A001A, 32'h00000055, 32'hAAAA,    32'hBBBB,    1'b0, 32'h11111111, 32'h44444444, 1'b1, 1'b0, 1'b0, 5'd11, 32'h00000001, 32'hAAAA,    32'hBBBB};

    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr        = 32'h0;
    alu_out      = 32'h0;
    alu_hi       = 32'h0;
    alu_lo       = 32'h0;
    alu_overflow = 1'b0;
    dbg_addr     = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checkPulses("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset hi_q", hi_q, 32'h0);
    checkOutput("reset lo_q", lo_q, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addiu $s1 then addu $s0,$s1,$s2 back to back: $s1 must be forwarded.
    instr_valid = 1'b1;
    instr       = 32'h24110064;
    alu_out     = 32'h00000064;
    @(posedge clk); #1;
    instr    = 32'h02328021;
    alu_out  = 32'h2ABBBBBA;
    dbg_addr = 5'd17;
    #1;
    checkOutput("fwd gr1", gr1, 32'h00000064);
    checkOutput("fwd gr2", gr2, 32'h0);
    checkOutput("fwd wb_done", {31'b0, wb_done}, 32'd1);
    checkOutput("fwd dbg17 precommit", dbg_rdata, 32'h0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checkOutput("fwd dbg17 committed", dbg_rdata, 32'h00000064);
    checkOutput("fwd addu wb_done", {31'b0, wb_done}, 32'd1);
    @(posedge clk); #1;
    dbg_addr = 5'd16;
    #1;
    checkOutput("fwd dbg16", dbg_rdata, 32'h2ABBBBBA);
    checkOutput("fwd idle wb_done", {31'b0, wb_done}, 32'd0);

    for (int i = 0; i < NVEC; i++) applyStimulus(i, vecs[i]);

    // A writeable instruction with instr_valid low must not commit.
    instr_valid = 1'b0;
    instr       = 32'h24110999;
    alu_out     = 32'h00000999;
    @(posedge clk); #1;
    checkPulses("novalid", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    dbg_addr = 5'd17;
    #1;
    checkOutput("novalid dbg17", dbg_rdata, 32'h00000064);

    // Reset mid-cycle with a write pending in W: the commit is lost.
    instr_valid = 1'b1;
    instr       = 32'h24120099;
    alu_out     = 32'h00000099;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checkOutput("rst pending wb_done", {31'b0, wb_done}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkPulses("rst mid", 1'b0, 1'b0, 1'b0);
    checkOutput("rst mid hi_q", hi_q, 32'h0);
    checkOutput("rst mid lo_q", lo_q, 32'h0);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #0.1;
      checkOutput($sformatf("rst dbg%0d", a), dbg_rdata, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkPulses("post rst", 1'b0, 1'b0, 1'b0);
    dbg_addr = 5'd18;
    #1;
    checkOutput("post rst dbg18", dbg_rdata, 32'h0);
    @(posedge clk); #1;
    checkPulses("post rst2", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
